// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one result bit per clock, LSB first, valid/ready on both sides.
// Define ALU_SERIAL_FLAGS_EN to build the carry/overflow/zero flag logic; otherwise the flags are tied to 0.
module alu_serial_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z
);

   localparam int unsigned   IW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic a_bit, b_bit, bb_bit, res_bit, cout;

   // Single bit slice driven by the captured operands at the current index.
   always_comb begin
      a_bit  = a_q[idx_q];
      b_bit  = b_q[idx_q];
      bb_bit = b_bit ^ op_q[0];
      cout   = (a_bit & bb_bit) | (carry_q & (a_bit ^ bb_bit));
      unique case (op_q[2:1])
         2'b00:   res_bit = a_bit ^ bb_bit ^ carry_q;
         2'b01:   res_bit = a_bit | bb_bit;
         2'b10:   res_bit = a_bit & bb_bit;
         default: res_bit = op_q[0] ? ~b_bit : ~a_bit;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               idx_d   = '0;
               carry_d = op[0];
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[idx_q] = res_bit;
            carry_d         = cout;
            idx_d           = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         result_q <= result_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;

`ifdef ALU_SERIAL_FLAGS_EN
   logic flag_c_q, flag_c_d;
   logic flag_v_q, flag_v_d;
   logic flag_z_q, flag_z_d;

   // Flags are latched on the edge that writes the MSB; carry_q then holds the carry into bit WIDTH-1.
   always_comb begin
      flag_c_d = flag_c_q;
      flag_v_d = flag_v_q;
      flag_z_d = flag_z_q;
      if ((state_q == RUN) && (idx_q == LAST)) begin
         if (op_q[2:1] == 2'b00) begin
            flag_c_d = cout;
            flag_v_d = carry_q ^ cout;
         end else begin
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
         end
         flag_z_d = (result_d == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         flag_c_q <= flag_c_d;
         flag_v_q <= flag_v_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign flag_c = flag_c_q;
   assign flag_v = flag_v_q;
   assign flag_z = flag_z_q;
`else
   assign flag_c = 1'b0;
   assign flag_v = 1'b0;
   assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: driver pushes model results, monitor pops them on out_valid.
// Flag expectations follow whether ALU_SERIAL_FLAGS_EN is defined in this compile.
module tb_alu_serial_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         flag_c, flag_v, flag_z;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_c    (flag_c),
      .flag_v    (flag_v),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
      int unsigned  acc;
      int unsigned  hold;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   busy  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Whole-word reference: arithmetic on the full operands, not a bit-serial loop.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t         e;
      logic [W-1:0] yy;
      logic [W:0]   full;
      yy   = o[0] ? ~y : y;
      full = '0;
      e.c  = 1'b0;
      e.v  = 1'b0;
      e.acc  = 0;
      e.hold = 0;
      case (o[2:1])
         2'b00: begin
            full  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o[0]};
            e.res = full[W-1:0];
`ifdef ALU_SERIAL_FLAGS_EN
            e.c = full[W];
            e.v = (x[W-1] == yy[W-1]) && (e.res[W-1] != x[W-1]);
`endif
         end
         2'b01:   e.res = x | yy;
         2'b10:   e.res = x & yy;
         default: e.res = o[0] ? ~y : ~x;
      endcase
`ifdef ALU_SERIAL_FLAGS_EN
      e.z = (e.res == '0);
`else
      e.z = 1'b0;
`endif
      return e;
   endfunction

   // Waits for IDLE while presenting junk (in_valid high), then issues one request.
   task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int unsigned hold);
      exp_t        e;
      int unsigned guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         in_valid = 1'b1;
         op = 3'($urandom);
         a  = W'($urandom);
         b  = W'($urandom);
         guard++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         return;
      end
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      e      = model(o, x, y);
      e.acc  = cyc + 1;
      e.hold = hold;
      sb.push_back(e);
      @(posedge clk);
      #1;
      op = 3'($urandom);
      a  = W'($urandom);
      b  = W'($urandom);
   endtask

   // Monitor: compare on first DONE cycle, then check outputs hold until the handshake.
   initial begin : monitor
      exp_t         e;
      logic [W-1:0] s_res;
      logic         s_c, s_v, s_z;
      int unsigned  holdcnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy      = 1'b0;
            out_ready = 1'b0;
         end else if (out_valid && !busy) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc - e.acc, W);
               chk("result", 32'(result), 32'(e.res));
               chk("flag_c", 32'(flag_c), 32'(e.c));
               chk("flag_v", 32'(flag_v), 32'(e.v));
               chk("flag_z", 32'(flag_z), 32'(e.z));
               chk("in_ready_in_done", 32'(in_ready), 32'd0);
               s_res = result;
               s_c = flag_c;
               s_v = flag_v;
               s_z = flag_z;
               holdcnt = e.hold;
               busy = 1'b1;
            end
            out_ready = (holdcnt == 0);
         end else if (busy && out_valid) begin
            chk("hold_result", 32'(result), 32'(s_res));
            chk("hold_flags", 32'({flag_c, flag_v, flag_z}), 32'({s_c, s_v, s_z}));
            chk("hold_no_accept", 32'(in_ready), 32'd0);
            if (holdcnt > 0) holdcnt--;
            out_ready = (holdcnt == 0);
         end else if (busy && !out_valid) begin
            chk("left_done_with_ready", 32'(out_ready), 32'd1);
            chk("idle_after_done", 32'(in_ready), 32'd1);
            busy      = 1'b0;
            out_ready = 1'b0;
         end
      end
   end

   initial begin : driver
      int unsigned guard;
      repeat (2) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
      rst = 1'b0;

      send(3'b000, 8'h7F, 8'h01, 0);
      send(3'b001, 8'h07, 8'h05, 1);
      send(3'b001, 8'h05, 8'h07, 0);
      send(3'b100, 8'hF0, 8'h3C, 2);
      send(3'b010, 8'hF0, 8'h3C, 0);
      send(3'b111, 8'h5A, 8'hFF, 0);
      send(3'b000, 8'h80, 8'h80, 5);
      send(3'b110, 8'h00, 8'h00, 0);

      // Abandon an add at bit index 4 with an asynchronous reset.
      send(3'b000, 8'hFF, 8'h01, 0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_rst_result", 32'(result), 32'd0);
      chk("midrun_rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
      void'(sb.pop_back());
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send(3'b000, 8'h01, 8'h01, 0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom);
         y = W'($urandom);
         if ($urandom_range(0, 7) == 0) x = '1;
         if ($urandom_range(0, 7) == 0) y = '0;
         send(3'($urandom), x, y, $urandom_range(0, 3));
      end

      in_valid = 1'b0;
      guard = 0;
      while ((sb.size() != 0 || busy) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0 || busy) chk("drain_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port op, input, 3 bits: the bit-slice control code c.
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 SHALL have port flag_c, output, 1 bit: the final carry out.
REQ-013 SHALL have port flag_v, output, 1 bit: the signed overflow flag.
REQ-014 SHALL have port flag_z, output, 1 bit: set when result is zero.

Function
REQ-015 SHALL compute op per bit, LSB first, one bit per clock.
- Let bb = b XOR op[0].
- op[2:1]=00: sum a+bb+cin.
- op[2:1]=01: a OR bb.
- op[2:1]=10: a AND bb.
- op[2:1]=11: NOT a when op[0]=0; NOT b when op[0]=1.
REQ-016 SHALL use three states:
- IDLE: in_ready=1.
- RUN: in_ready=0, out_valid=0.
- DONE: out_valid=1, in_ready=0.
REQ-017 SHALL, on a rising edge with in_valid=1 in IDLE, capture op, a and b, clear the bit index, load the carry register with op[0], and enter RUN.
REQ-018 SHALL, in each RUN cycle with bit index i, write result bit i, load the carry register with that bit's carry out, and increment i.
REQ-019 SHALL move from RUN to DONE on the edge that processes bit WIDTH-1, so out_valid asserts exactly WIDTH cycles after the accepting edge.
REQ-020 SHALL hold result and all flags stable while in DONE.
REQ-021 SHALL leave DONE for IDLE on a rising edge with out_ready=1; a new request SHALL only be accepted in the following IDLE cycle, giving no same-edge accept.
REQ-022 SHALL ignore in_valid, op, a and b outside IDLE; operands SHALL come from captured copies only.
REQ-023 SHALL, when out_ready is held low, stay in DONE indefinitely without changing any output.
REQ-024 SHALL ignore a carry out of bit WIDTH-1 for all subsequent operations; the carry register SHALL be reloaded on every accept.
REQ-025 SHALL, for op[2:1]=00 only, set flag_c to the final carry and flag_v to the carry into bit WIDTH-1 XOR the final carry; for all other ops flag_c=0 and flag_v=0.

Reset
REQ-026 SHALL, while rst=1, immediately force:
- state IDLE, in_ready=1, out_valid=0;
- result=0, all flags 0;
- carry register 0 and bit index 0.
REQ-027 SHALL, when rst asserts mid-RUN or in DONE, abandon the operation with no output handshake; the first accept after rst deasserts SHALL start a fresh operation.

Configuration
REQ-028 SHALL, with macro ALU_SERIAL_FLAGS_EN defined, drive flag_c, flag_v and flag_z per REQ-014 and REQ-025.
REQ-029 SHALL, without ALU_SERIAL_FLAGS_EN, keep the flag ports and tie them to constant 0, with no flag logic present; handshake, result and latency SHALL be unchanged.

Verification (WIDTH=8, ALU_SERIAL_FLAGS_EN defined)
REQ-030 SHALL cover: op=000, a=0x7F, b=0x01 -> result=0x80, flag_c=0, flag_v=1, flag_z=0, out_valid exactly 8 cycles after accept.
REQ-031 SHALL cover: op=001, a=0x07, b=0x05 -> result=0x02, flag_c=1, flag_v=0; then op=001, a=0x05, b=0x07 -> result=0xFE, flag_c=0.
REQ-032 SHALL cover:
- op=100, a=0xF0, b=0x3C -> result=0x30.
- op=010 on the same operands -> 0xFC.
- op=111, b=0xFF -> 0x00 with flag_z=1, flag_c=0.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE, with in_valid=1 and changing a -> out_valid, result and flags constant and no accept; out_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover: rst pulsed at bit index 4 of op=000, a=0xFF, b=0x01 -> all outputs 0 and in_ready=1 immediately; then op=000, a=0x01, b=0x01 -> result=0x02, flag_c=0.
REQ-035 SHALL cover: rebuild without ALU_SERIAL_FLAGS_EN and rerun REQ-030 -> result=0x80 with same latency, all flags 0.
